// File: rtl/neptuno_joyencoder.sv
// NeptUNO joystick link responder: latches two 6-button pads on load,
// then shifts them out one bit per host clock rising edge.
module neptuno_joyencoder #(
  parameter int   FRAME_BITS  = 16,
  parameter logic FILL        = 1'b1,
  parameter int   SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] joy1_i,
  input  logic [5:0] joy2_i,
  input  logic       joy_load_i,
  input  logic       joy_clk_i,
  output logic       joy_data_o,
  output logic       frame_done_o,
  output logic [7:0] abort_cnt_o
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  state_t                 state;
  logic [FRAME_BITS-1:0]  shift_reg;
  logic [CW-1:0]          bit_cnt;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic                   load_low;
  logic [FRAME_BITS-1:0]  frame;

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign load_s   = load_sync[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_prev;
  assign load_low = ~load_s;

  // Pad bits default to FILL; the 12 pad bits sit at the MSB end.
  always_comb begin
    frame = {FRAME_BITS{FILL}};
    frame[FRAME_BITS-1 -: 12] = {~joy1_i, ~joy2_i};
  end

  // Reset to 1 so idle-high wires give no false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= '1;
      load_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk_i};
      load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load_i};
      clk_prev  <= clk_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shift_reg    <= {FRAME_BITS{FILL}};
      bit_cnt      <= '0;
      joy_data_o   <= FILL;
      frame_done_o <= 1'b0;
      abort_cnt_o  <= 8'd0;
    end else begin
      frame_done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          joy_data_o <= FILL;
          if (load_low) state <= LOAD;
        end
        LOAD: begin
          if (load_low) begin
            shift_reg  <= frame;
            joy_data_o <= frame[FRAME_BITS-1];
          end else begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          // Load has priority over a coincident clock edge.
          if (load_low) begin
            state <= LOAD;
            if (bit_cnt != '0 && abort_cnt_o != 8'hFF)
              abort_cnt_o <= abort_cnt_o + 8'd1;
          end else if (clk_rise) begin
            if (bit_cnt == LAST) begin
              frame_done_o <= 1'b1;
              joy_data_o   <= FILL;
              state        <= DONE;
            end else begin
              shift_reg  <= {shift_reg[FRAME_BITS-2:0], FILL};
              joy_data_o <= shift_reg[FRAME_BITS-2];
              bit_cnt    <= bit_cnt + 1'b1;
            end
          end
        end
        DONE: begin
          joy_data_o <= FILL;
          if (load_low) state <= LOAD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
